// File: rtl/uart_rx_dois_bytes.sv
// Two-byte 8N1 UART receiver: captures a command pair from the PC serial line
// and reports it with a one-cycle valid strobe, plus framing and inter-byte timeout pulses.
//
// state           | meaning
// ESPERA          | line idle, waiting for a start edge (runs inter-byte timeout after byte 1)
// VERIFICA_INICIO | confirming the start bit at its middle
// RECEBE_BITS     | sampling the 8 data bits at mid-bit, LSB first
// VERIFICA_FINAL  | sampling the stop bit; stores byte 1 or delivers the pair
// LIMPEZA         | waiting for the line to return high before rearming
module uart_rx_dois_bytes #(
  parameter int CLOKS_POR_BIT = 5209,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       bitSerialRecebido,
  output logic [7:0] primeiroByteRecebido,
  output logic [7:0] segundoByteRecebido,
  output logic       dadosRecebidosValidos,
  output logic       indicaRecepcao,
  output logic       erroDeQuadro,
  output logic       erroTempoEsgotado
);

  localparam int TMO_CICLOS = TIMEOUT_BITS * CLOKS_POR_BIT;
  localparam int TMO_W      = $clog2(TMO_CICLOS + 1);

  localparam logic [12:0]      FIM_BIT  = 13'(CLOKS_POR_BIT - 1);
  localparam logic [12:0]      MEIO_BIT = 13'((CLOKS_POR_BIT - 1) / 2);
  localparam logic [TMO_W-1:0] FIM_TMO  = TMO_W'(TMO_CICLOS - 1);

  typedef enum logic [2:0] {
    ESPERA,
    VERIFICA_INICIO,
    RECEBE_BITS,
    VERIFICA_FINAL,
    LIMPEZA
  } estado_t;

  estado_t          estado;
  logic             rx_meta;
  logic             rxs;
  logic [12:0]      cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [2:0]       bit_idx;
  logic             byte_idx;
  logic [7:0]       shift;
  logic [7:0]       buffer;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta               <= 1'b1;
      rxs                   <= 1'b1;
      estado                <= ESPERA;
      cnt                   <= '0;
      tmo_cnt               <= '0;
      bit_idx               <= '0;
      byte_idx              <= 1'b0;
      shift                 <= '0;
      buffer                <= '0;
      primeiroByteRecebido  <= '0;
      segundoByteRecebido   <= '0;
      dadosRecebidosValidos <= 1'b0;
      indicaRecepcao        <= 1'b0;
      erroDeQuadro          <= 1'b0;
      erroTempoEsgotado     <= 1'b0;
    end else begin
      rx_meta               <= bitSerialRecebido;
      rxs                   <= rx_meta;
      dadosRecebidosValidos <= 1'b0;
      erroDeQuadro          <= 1'b0;
      erroTempoEsgotado     <= 1'b0;

      case (estado)
        ESPERA: begin
          cnt <= '0;
          // A start edge takes priority over an expiring timeout.
          if (!rxs) begin
            estado <= VERIFICA_INICIO;
          end else if (byte_idx) begin
            if (tmo_cnt == FIM_TMO) begin
              erroTempoEsgotado <= 1'b1;
              byte_idx          <= 1'b0;
              tmo_cnt           <= '0;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        VERIFICA_INICIO: begin
          if (cnt == MEIO_BIT) begin
            cnt <= '0;
            if (!rxs) begin
              bit_idx        <= '0;
              indicaRecepcao <= 1'b1;
              estado         <= RECEBE_BITS;
            end else begin
              estado <= ESPERA;
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end

        RECEBE_BITS: begin
          if (cnt == FIM_BIT) begin
            cnt            <= '0;
            shift[bit_idx] <= rxs;
            if (bit_idx == 3'd7) estado <= VERIFICA_FINAL;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 13'd1;
          end
        end

        VERIFICA_FINAL: begin
          if (cnt == FIM_BIT) begin
            cnt            <= '0;
            indicaRecepcao <= 1'b0;
            estado         <= LIMPEZA;
            if (!rxs) begin
              erroDeQuadro <= 1'b1;
              byte_idx     <= 1'b0;
            end else if (!byte_idx) begin
              buffer   <= shift;
              byte_idx <= 1'b1;
              tmo_cnt  <= '0;
            end else begin
              primeiroByteRecebido  <= buffer;
              segundoByteRecebido   <= shift;
              dadosRecebidosValidos <= 1'b1;
              byte_idx              <= 1'b0;
            end
          end else begin
            cnt <= cnt + 13'd1;
          end
        end

        LIMPEZA: begin
          // A held-low line (break) must not be mistaken for a new start bit.
          if (rxs) estado <= ESPERA;
        end

        default: estado <= ESPERA;
      endcase
    end
  end

endmodule
